// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM state encoding and framing constants
package uart_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
   localparam int DATA_BITS = 8;
   localparam int CLKS_PER_BIT_DEF = 16;
endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: small byte FIFO; a push into a full FIFO succeeds only alongside a pop
module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [DATA_BITS-1:0]   din,
   output logic [DATA_BITS-1:0]   dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   logic [DATA_BITS-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign full    = count == (AW+1)'(DEPTH);
   assign empty   = count == '0;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/uart_echo_responder.sv
// uart_echo_responder: 8N1 receiver feeding a byte FIFO that is retransmitted unchanged on tx
module uart_echo_responder
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        rx,
   output logic                        tx,
   input  logic                        tx_enable,
   output logic [7:0]                  rx_byte,
   output logic                        rx_valid,
   output logic                        frame_err,
   output logic                        overflow,
   output logic                        tx_busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   logic rx_m, rx_s;
   uart_state_t rx_state, rx_next, tx_state, tx_next;
   logic [CW-1:0] rx_cnt, tx_cnt;
   logic [2:0] rx_bit, tx_bit;
   logic [7:0] rx_shift, tx_data, head;
   logic rx_tick, rx_half, rx_stop, tx_tick, pop, full, empty;
   always_ff @(posedge clk or negedge rst)
      if (!rst) {rx_m, rx_s} <= 2'b11;
      else {rx_m, rx_s} <= {rx, rx_m};
   assign rx_tick = rx_cnt == CW'(CLKS_PER_BIT - 1);
   assign rx_half = rx_cnt == CW'(CLKS_PER_BIT / 2 - 1);
   assign rx_stop = rx_state == STOP && rx_tick;
   always_ff @(posedge clk or negedge rst)
      if (!rst) rx_state <= IDLE;
      else rx_state <= rx_next;
   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         IDLE:    rx_next = rx_s ? IDLE : START;
         START:   rx_next = rx_half ? (rx_s ? IDLE : DATA) : START;
         DATA:    rx_next = (rx_tick && rx_bit == 3'd7) ? STOP : DATA;
         default: rx_next = rx_tick ? IDLE : STOP;
      endcase
   end
   // the start-bit check restarts the baud counter so data samples land mid-bit
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         rx_cnt    <= '0;
         rx_bit    <= '0;
         rx_shift  <= '0;
         rx_byte   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_cnt    <= (rx_state == IDLE || (rx_state == START && rx_half) || rx_tick) ? '0 : rx_cnt + 1'b1;
         rx_valid  <= rx_stop && rx_s;
         frame_err <= rx_stop && !rx_s;
         if (rx_state == DATA && rx_tick) begin
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
         end
         if (rx_stop && rx_s) rx_byte <= rx_shift;
      end
   uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push(rx_valid), .pop(pop), .din(rx_byte), .dout(head),
      .full(full), .empty(empty), .count(fifo_count)
   );
   assign overflow = rx_valid && full && !pop;
   assign tx_tick  = tx_cnt == CW'(CLKS_PER_BIT - 1);
   assign pop      = tx_state == IDLE && !empty && tx_enable;
   always_ff @(posedge clk or negedge rst)
      if (!rst) tx_state <= IDLE;
      else tx_state <= tx_next;
   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         IDLE:    tx_next = pop ? START : IDLE;
         START:   tx_next = tx_tick ? DATA : START;
         DATA:    tx_next = (tx_tick && tx_bit == 3'd7) ? STOP : DATA;
         default: tx_next = tx_tick ? IDLE : STOP;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         tx_cnt  <= '0;
         tx_bit  <= '0;
         tx_data <= '0;
      end else begin
         tx_cnt <= (tx_state == IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
         if (pop) tx_data <= head;
         if (tx_state == DATA && tx_tick) tx_bit <= tx_bit + 1'b1;
      end
   always_comb begin
      tx      = tx_state == START ? 1'b0 : tx_state == DATA ? tx_data[tx_bit] : 1'b1;
      tx_busy = tx_state != IDLE;
   end
endmodule

// File: tb/tb_uart_echo_responder.sv
// tb_uart_echo_responder: directed vector table plus hand sequences for glitch, overflow, reset and back-to-back
module tb_uart_echo_responder;
   logic clk = 1'b0, rst = 1'b0, rx = 1'b1, tx_enable = 1'b0;
   logic tx, rx_valid, frame_err, overflow, tx_busy;
   logic [7:0] rx_byte;
   logic [2:0] fifo_count;
   int n_chk = 0, n_fail = 0, cyc = 0, n_valid = 0, n_ferr = 0, n_ovf = 0, valid_cyc = 0;
   logic [7:0] q_byte[$];
   bit q_ok[$];
   int q_start[$];
   logic [9:0] mon_lv;
   bit mon_ok;
   int mon_s;

   typedef struct {
      logic [7:0] d;
      logic       stop;
      int         ev;
      int         ef;
      logic [7:0] eb;
   } vec_t;
   vec_t vt[6];

   uart_echo_responder dut (
      .clk(clk), .rst(rst), .rx(rx), .tx(tx), .tx_enable(tx_enable), .rx_byte(rx_byte),
      .rx_valid(rx_valid), .frame_err(frame_err), .overflow(overflow), .tx_busy(tx_busy),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk)
      if (rst) begin
         if (rx_valid) begin
            n_valid   <= n_valid + 1;
            valid_cyc <= cyc;
         end
         if (frame_err) n_ferr <= n_ferr + 1;
         if (overflow) n_ovf <= n_ovf + 1;
      end

   // decodes echoed frames, requiring every bit level to hold for its whole 16-cycle period
   initial forever begin
      @(negedge clk);
      if (rst && tx === 1'b0) begin
         mon_s  = cyc;
         mon_ok = 1'b1;
         for (int b = 0; b < 10; b++)
            for (int j = 0; j < 16; j++) begin
               if (b != 0 || j != 0) @(negedge clk);
               if (j == 0) mon_lv[b] = tx;
               else if (tx !== mon_lv[b]) mon_ok = 1'b0;
            end
         if (mon_lv[0] !== 1'b0 || mon_lv[9] !== 1'b1) mon_ok = 1'b0;
         q_byte.push_back(mon_lv[8:1]);
         q_ok.push_back(mon_ok);
         q_start.push_back(mon_s);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] d, input logic stop);
      rx = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (16) @(negedge clk);
      end
      rx = stop;
      repeat (16) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tx_quiet(input int n, input string name);
      int bad = 0;
      repeat (n) begin
         @(negedge clk);
         if (tx !== 1'b1) bad++;
      end
      chk(name, bad, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bv, bf, bo, bq;
      bit seen;
      vt[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
      vt[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
      vt[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
      vt[3] = '{8'h81, 1'b0, 0, 1, 8'h00};
      vt[4] = '{8'h5A, 1'b1, 1, 0, 8'h5A};
      vt[5] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
      idle(3);
      chk("reset_tx", tx, 1);
      chk("reset_rx_byte", rx_byte, 0);
      chk("reset_flags", {rx_valid, frame_err, overflow, tx_busy}, 0);
      chk("reset_count", fifo_count, 0);
      rst = 1'b1;
      tx_enable = 1'b1;
      idle(5);

      for (int i = 0; i < 6; i++) begin
         bv = n_valid; bf = n_ferr; bq = q_byte.size();
         send(vt[i].d, vt[i].stop);
         idle(200);
         chk($sformatf("v%0d_valid", i), n_valid - bv, vt[i].ev);
         chk($sformatf("v%0d_ferr", i), n_ferr - bf, vt[i].ef);
         chk($sformatf("v%0d_rx_byte", i), rx_byte, vt[i].eb);
         chk($sformatf("v%0d_count", i), fifo_count, 0);
         chk($sformatf("v%0d_echoes", i), q_byte.size() - bq, vt[i].ev);
         if (vt[i].ev == 1 && q_byte.size() > bq) begin
            chk($sformatf("v%0d_echo_byte", i), q_byte[$], vt[i].d);
            chk($sformatf("v%0d_echo_shape", i), q_ok[$], 1);
            chk($sformatf("v%0d_latency", i), q_start[$] - valid_cyc, 2);
         end
      end

      bv = n_valid; bf = n_ferr;
      rx = 1'b0;
      idle(4);
      rx = 1'b1;
      tx_quiet(200, "glitch_tx_idle");
      chk("glitch_valid", n_valid - bv, 0);
      chk("glitch_ferr", n_ferr - bf, 0);
      chk("glitch_count", fifo_count, 0);

      tx_enable = 1'b0;
      bv = n_valid; bo = n_ovf;
      for (int b = 1; b <= 5; b++) begin
         send(8'(b), 1'b1);
         if (b == 4) begin
            idle(4);
            chk("ovf_count_at4", fifo_count, 4);
            chk("ovf_none_at4", n_ovf - bo, 0);
         end
      end
      idle(10);
      chk("ovf_valid5", n_valid - bv, 5);
      chk("ovf_pulse", n_ovf - bo, 1);
      chk("ovf_count_full", fifo_count, 4);
      chk("ovf_tx_blocked", tx_busy, 0);
      bq = q_byte.size();
      tx_enable = 1'b1;
      idle(4 * 161 + 50);
      chk("drain_echoes", q_byte.size() - bq, 4);
      if (q_byte.size() == bq + 4)
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain_byte%0d", k), q_byte[bq+k], k + 1);
            chk($sformatf("drain_shape%0d", k), q_ok[bq+k], 1);
         end
      chk("drain_count", fifo_count, 0);

      bq = q_byte.size(); bo = n_ovf;
      send(8'h00, 1'b1);
      send(8'hFF, 1'b1);
      idle(400);
      chk("b2b_echoes", q_byte.size() - bq, 2);
      chk("b2b_overflow", n_ovf - bo, 0);
      if (q_byte.size() == bq + 2) begin
         chk("b2b_byte0", q_byte[bq], 8'h00);
         chk("b2b_byte1", q_byte[bq+1], 8'hFF);
         chk("b2b_shape", {q_ok[bq], q_ok[bq+1]}, 2'b11);
         chk("b2b_gap", q_start[bq+1] - q_start[bq], 161);
      end

      send(8'hFF, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (tx === 1'b0) seen = 1'b1;
      end
      chk("rst_echo_started", seen, 1);
      idle(40);
      chk("rst_busy_before", tx_busy, 1);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("rst_async_tx", tx, 1);
      chk("rst_async_busy", tx_busy, 0);
      chk("rst_async_count", fifo_count, 0);
      chk("rst_async_rx_byte", rx_byte, 0);
      idle(3);
      rst = 1'b1;
      tx_quiet(400, "rst_tx_quiet");
      chk("rst_busy_after", tx_busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
